// File: rtl/cpu_prog_loader_if.sv
// Host-side load handshake and CPU-side program RAM / reset bundle of the program loader.
interface cpu_prog_loader_if #(
    parameter int ADDR_W = 4
);
    logic              load_en;
    logic              load_strobe;
    logic [7:0]        load_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst_n;
    logic              load_busy;
    logic              load_err;
    logic [ADDR_W:0]   byte_count;

    // Host / pin-mux side: drives the load pins, observes RAM writes and status.
    modport master (
        output load_en, load_strobe, load_data,
        input  mem_we, mem_addr, mem_wdata, cpu_rst_n, load_busy, load_err, byte_count
    );

    // Loader side: consumes the load pins, drives RAM writes and status.
    modport slave (
        input  load_en, load_strobe, load_data,
        output mem_we, mem_addr, mem_wdata, cpu_rst_n, load_busy, load_err, byte_count
    );
endinterface

// File: rtl/cpu_prog_loader.sv
// Program loader: synchronizes the load pins, streams bytes into program RAM,
// verifies a trailing two's-complement checksum and gates the CPU core reset.
module cpu_prog_loader #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    cpu_prog_loader_if.slave  bus
);
    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] en_chain;
    logic [SYNC_STAGES-1:0] strobe_chain;
    logic                   prev_strobe;
    logic                   prev_en;
    logic [7:0]             checksum;

    logic                   sync_en;
    logic                   sync_strobe;
    logic                   str_rise;
    logic                   en_rise;
    logic                   en_fall;
    logic [7:0]             check_total;

    assign sync_en     = en_chain[SYNC_STAGES-1];
    assign sync_strobe = strobe_chain[SYNC_STAGES-1];
    assign str_rise    = ena & sync_strobe & ~prev_strobe;
    assign en_rise     = ena & sync_en & ~prev_en;
    assign en_fall     = ena & ~sync_en & prev_en;
    assign check_total = checksum + bus.load_data;

    // Bring the asynchronous pins into the clock domain and keep last-cycle copies for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_chain     <= '0;
            strobe_chain <= '0;
            prev_strobe  <= 1'b0;
            prev_en      <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1) begin
                en_chain     <= {en_chain[SYNC_STAGES-2:0], bus.load_en};
                strobe_chain <= {strobe_chain[SYNC_STAGES-2:0], bus.load_strobe};
            end else begin
                en_chain     <= {SYNC_STAGES{bus.load_en}};
                strobe_chain <= {SYNC_STAGES{bus.load_strobe}};
            end
            prev_strobe <= sync_strobe;
            prev_en     <= sync_en;
        end
    end

    // Load sequencer with registered RAM-write, status and core-reset outputs; frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.cpu_rst_n  <= 1'b0;
            bus.load_busy  <= 1'b0;
            bus.load_err   <= 1'b0;
            bus.byte_count <= '0;
            checksum       <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (ena) begin
                case (state)
                    IDLE: begin
                        bus.cpu_rst_n <= 1'b0;
                        bus.load_busy <= 1'b0;
                        if (sync_en) begin
                            state          <= LOAD;
                            bus.load_busy  <= 1'b1;
                            bus.byte_count <= '0;
                            bus.mem_addr   <= '0;
                            checksum       <= '0;
                            bus.load_err   <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (bus.byte_count == FULL_COUNT) begin
                            state <= CHECK;
                        end else if (!sync_en) begin
                            state <= CHECK;
                        end else if (str_rise) begin
                            bus.mem_we     <= 1'b1;
                            bus.mem_wdata  <= bus.load_data;
                            bus.mem_addr   <= bus.byte_count[ADDR_W-1:0];
                            checksum       <= check_total;
                            bus.byte_count <= bus.byte_count + COUNT_ONE;
                        end
                    end
                    CHECK: begin
                        if (str_rise) begin
                            bus.load_busy <= 1'b0;
                            if (check_total == 8'h00) begin
                                state         <= RUN;
                                bus.cpu_rst_n <= 1'b1;
                            end else begin
                                state        <= ERROR;
                                bus.load_err <= 1'b1;
                            end
                        end else if (en_fall) begin
                            state         <= ERROR;
                            bus.load_busy <= 1'b0;
                            bus.load_err  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (en_rise) begin
                            state          <= LOAD;
                            bus.cpu_rst_n  <= 1'b0;
                            bus.load_busy  <= 1'b1;
                            bus.byte_count <= '0;
                            bus.mem_addr   <= '0;
                            checksum       <= '0;
                        end
                    end
                    ERROR: begin
                        if (en_rise) begin
                            state          <= LOAD;
                            bus.load_busy  <= 1'b1;
                            bus.load_err   <= 1'b0;
                            bus.byte_count <= '0;
                            bus.mem_addr   <= '0;
                            checksum       <= '0;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        bus.cpu_rst_n <= 1'b0;
                        bus.load_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
